// File: rtl/rom_data_fifo.sv
// rtl/rom_data_fifo.sv - first-word-fall-through byte FIFO for the ROM read path
// Also tracks a sticky overflow flag, a saturating drop counter and a checksum of accepted bytes.
module rom_data_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    checksum
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  // Full/empty come from level only, so in_ready never depends on out_ready.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign drop = in_valid & ~in_ready;

  // Storage is not reset; out_data is meaningless until out_valid rises.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
      checksum <= 8'h00;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
      checksum <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        checksum <= checksum + 8'(in_data);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'h01;
        end
      end
    end
  end

endmodule
